adc_hex_uart: RTL and testbench
===============================

// Module: adc_hex_uart
// PURPOSE
//  Downstream consumer of the sigma-delta filter output word. Captures a 16-bit
//  filtered sample on a one-cycle strobe and streams it as one ASCII line
//  "HHHH\r\n" (4 uppercase hex digits + CR + LF) on a UART TX pin.
//  One-deep holding buffer absorbs a sample that arrives mid-line; a sticky flag
//  reports lost samples. Lets a PC terminal log ADC values on one spare output pin.
// PARAMETERS
//  BAUD_DIV  87  clk cycles per UART bit (10 MHz / 115200); legal range 2..65535
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   reset, synchronous, active-low
//  sample      in   16  filtered ADC word, sampled only when sample_vld=1
//  sample_vld  in   1   one-cycle strobe (decimation-rate enable)
//  enable      in   1   1 = accept new samples; 0 = finish current line, then idle
//  txd         out  1   UART TX, 8N1, LSB first, idle high
//  busy        out  1   1 while a line is being transmitted
//  overrun     out  1   sticky: a held sample was overwritten before it was sent
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): txd=1, busy=0, overrun=0, holding empty, FSM IDLE,
//   all counters 0. Applies mid-line too: txd back to 1 on the next edge, line dropped.
//  FSM: IDLE -> START -> DATA -> STOP -> (START of next char | IDLE | START of next line).
//   IDLE:  txd=1. sample_vld & enable: load sample into line register, char index=0,
//          enter START. txd falls on the edge after the strobe (latency 1 cycle).
//   START: txd=0 for BAUD_DIV cycles.  DATA: 8 bits LSB first, BAUD_DIV cycles each.
//   STOP:  txd=1 for BAUD_DIV cycles; then char index+1 -> START with no idle gap,
//          or after char 5 the line ends.
//  Chars 0..5: hex(sample[15:12]), hex([11:8]), hex([7:4]), hex([3:0]), 8'h0D, 8'h0A.
//   hex(n) = 8'h30+n for n<=9, 8'h37+n for n>=10 ('A'..'F').
//  Line = 60 bit-times = 60*BAUD_DIV cycles. Baud counter restarts at each START.
//  busy=1 from the first START cycle through the last STOP cycle of the line.
//  Strobe while busy & enable: sample written to holding register. If holding was
//   already full, it is overwritten (newest wins) and overrun set to 1.
//  Line end: holding full -> next line starts on the next cycle (busy stays 1, txd
//   goes 0), holding emptied; else sample_vld & enable on that same cycle ->
//   that sample starts directly; else IDLE.
//  Line end with holding full AND sample_vld: held word starts, new word enters
//   holding; no overrun.
//  enable=0: strobes ignored (no holding write, no overrun); a line in progress
//   completes; holding register cleared so no further line starts.
//  overrun cleared only by reset. sample changing while sample_vld=0 has no effect.
// TESTING (bench with BAUD_DIV=4)
//  1 Reset, enable=1, strobe 16'h3A7F -> txd low on next edge; decoded bytes
//    33 41 37 46 0D 0A; busy high exactly 240 cycles; overrun=0.
//  2 Strobe 16'h0009, strobe 16'hFFFF 50 cycles later -> line "0009\r\n" then
//    back-to-back "FFFF\r\n"; busy never drops between lines; overrun=0.
//  3 Strobe 16'h1234, then 16'h5555 and 16'hABCD mid-line -> lines "1234", "ABCD";
//    overrun=1 and stays 1 until rst_n=0.
//  4 Strobe 16'h0000, deassert enable at cycle 100, strobe 16'h1111 at cycle 120
//    -> "0000\r\n" completes, no second line, busy=0 afterwards, overrun=0.
//  5 Strobe 16'hBEEF, rst_n=0 for 1 cycle at cycle 70 -> txd=1, busy=0 on the
//    following edge; fresh strobe 16'h0001 yields a clean "0001\r\n".
//  6 Hold a sample, strobe on the exact line-end cycle -> held line starts next
//    cycle, new sample sent third, overrun=0.

Source files
------------

// File: rtl/adc_hex_uart.sv
// ---------------------------------------------------------------------------
// adc_hex_uart
// Streams each captured 16-bit filtered ADC word as one ASCII line "HHHH\r\n"
// (four uppercase hex digits, CR, LF) on a UART TX pin, 8N1, LSB first.
// A one-deep holding register absorbs a sample that arrives while a line is
// in flight; a sticky flag reports samples lost by overwriting that register.
//
// Ports
//   clk         in   1   system clock
//   rst_n       in   1   synchronous active-low reset
//   sample      in   16  filtered ADC word, used only while sample_vld=1
//   sample_vld  in   1   one-cycle capture strobe
//   enable      in   1   1 = accept samples; 0 = finish current line, then idle
//   txd         out  1   UART TX line, idle high
//   busy        out  1   high while a line is being transmitted
//   overrun     out  1   sticky: a held sample was overwritten before sending
// ---------------------------------------------------------------------------
module adc_hex_uart #(
    parameter int unsigned BAUD_DIV = 87
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sample,
    input  logic        sample_vld,
    input  logic        enable,
    output logic        txd,
    output logic        busy,
    output logic        overrun
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_START  = 2'd1;
    localparam logic [1:0]  ST_DATA   = 2'd2;
    localparam logic [1:0]  ST_STOP   = 2'd3;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  CHAR_LAST = 3'd5;

    // ASCII code of one hex nibble, uppercase letters
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] c;
        if (n <= 4'd9) begin
            c = 8'h30 + {4'h0, n};
        end else begin
            c = 8'h37 + {4'h0, n};
        end
        return c;
    endfunction

    // Character idx of the line built from word w
    function automatic logic [7:0] line_char(input logic [15:0] w, input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = hex_char(w[15:12]);
            3'd1:    c = hex_char(w[11:8]);
            3'd2:    c = hex_char(w[7:4]);
            3'd3:    c = hex_char(w[3:0]);
            3'd4:    c = 8'h0D;
            3'd5:    c = 8'h0A;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    logic [1:0]  state_q,    state_d;
    logic [15:0] baud_q,     baud_d;
    logic [2:0]  bit_q,      bit_d;
    logic [2:0]  char_q,     char_d;
    logic [15:0] line_q,     line_d;
    logic [15:0] hold_q,     hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        overrun_q,  overrun_d;
    logic        txd_q,      txd_d;
    logic        busy_q,     busy_d;

    logic        accept_s;
    logic        baud_done_s;
    logic        line_end_s;
    logic        hold_go_s;
    logic [7:0]  char_byte_s;

    assign accept_s    = sample_vld && enable;
    assign baud_done_s = (baud_q == BAUD_LAST);
    assign line_end_s  = (state_q == ST_STOP) && baud_done_s && (char_q == CHAR_LAST);
    // A held word only launches while enable is still high
    assign hold_go_s   = hold_vld_q && enable;

    // Next-state logic: bit framing FSM, holding register and line-start choice
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        char_d     = char_q;
        line_d     = line_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        overrun_d  = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_START;
                    line_d  = sample;
                    char_d  = 3'd0;
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d  = 16'd0;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    state_d = ST_DATA;
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    baud_d = 16'd0;
                    bit_d  = 3'd0;
                    if (char_q != CHAR_LAST) begin
                        state_d = ST_START;
                        char_d  = char_q + 3'd1;
                    end else if (hold_go_s) begin
                        // Held word has priority over a strobe on the same cycle
                        state_d = ST_START;
                        char_d  = 3'd0;
                        line_d  = hold_q;
                    end else if (accept_s) begin
                        state_d = ST_START;
                        char_d  = 3'd0;
                        line_d  = sample;
                    end else begin
                        state_d = ST_IDLE;
                        char_d  = 3'd0;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = 16'd0;
                bit_d   = 3'd0;
                char_d  = 3'd0;
            end
        endcase

        if (!enable) begin
            hold_vld_d = 1'b0;
        end else if (line_end_s && hold_vld_q) begin
            // Held word leaves; a same-cycle strobe refills without overrun
            hold_vld_d = sample_vld;
            if (sample_vld) begin
                hold_d = sample;
            end else begin
                hold_d = hold_q;
            end
        end else if (sample_vld && (state_q != ST_IDLE) && !line_end_s) begin
            if (hold_vld_q) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
            hold_d     = sample;
            hold_vld_d = 1'b1;
        end else begin
            hold_vld_d = hold_vld_q;
        end
    end

    assign char_byte_s = line_char(line_d, char_d);

    // Output decode from the next state so txd and busy come straight from flops
    always_comb begin
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = char_byte_s[bit_d];
            ST_STOP:  txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
        if (state_d != ST_IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= 16'd0;
            bit_q      <= 3'd0;
            char_q     <= 3'd0;
            line_q     <= 16'd0;
            hold_q     <= 16'd0;
            hold_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            char_q     <= char_d;
            line_q     <= line_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            overrun_q  <= overrun_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_adc_hex_uart.sv
// ---------------------------------------------------------------------------
// tb_adc_hex_uart
// Directed bench for adc_hex_uart at BAUD_DIV=4. A background receiver decodes
// UART frames into a byte queue; a background monitor counts busy cycles and
// busy falling edges. Expected lines are hand-written ASCII byte strings.
// ---------------------------------------------------------------------------
module tb_adc_hex_uart;

    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sample;
    logic        sample_vld;
    logic        enable;
    logic        txd;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q[$];
    int         busy_cnt   = 0;
    int         busy_falls = 0;
    logic       busy_prev  = 1'b0;

    adc_hex_uart #(.BAUD_DIV(BD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample     (sample),
        .sample_vld (sample_vld),
        .enable     (enable),
        .txd        (txd),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Busy activity monitor
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (busy_prev === 1'b1 && busy === 1'b0) busy_falls <= busy_falls + 1;
        busy_prev <= busy;
    end

    // UART receiver: detect start bit, sample each bit mid-way
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (BD + BD / 2) @(negedge clk);
                b[0] = txd;
                for (int i = 1; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BD) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        sample     = v;
        sample_vld = 1'b1;
        @(negedge clk);
        sample_vld = 1'b0;
        sample     = 16'hDEAD;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_timeout", {63'd0, busy}, 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_line(input string tag, input int base, input logic [47:0] exp);
        logic [47:0] g = 48'd0;
        for (int k = 0; k < 6; k++) begin
            if (base + k < rx_q.size()) g = {g[39:0], rx_q[base + k]};
            else                        g = {g[39:0], 8'h00};
        end
        check_eq(tag, {16'd0, g}, {16'd0, exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int b0;
        int f0;
        rst_n      = 1'b0;
        sample     = 16'h0000;
        sample_vld = 1'b0;
        enable     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_txd", {63'd0, txd}, 64'd1);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_ovr", {63'd0, overrun}, 64'd0);
        enable = 1'b1;

        // 1: single line, latency and busy length
        base = rx_q.size(); b0 = busy_cnt; f0 = busy_falls;
        @(negedge clk);
        check_eq("t1_pre_txd", {63'd0, txd}, 64'd1);
        strobe(16'h3A7F);
        check_eq("t1_lat_txd", {63'd0, txd}, 64'd0);
        check_eq("t1_lat_busy", {63'd0, busy}, 64'd1);
        wait_idle(400);
        check_line("t1_line", base, 48'h33_41_37_46_0D_0A);
        check_eq("t1_nbytes", 64'(rx_q.size() - base), 64'd6);
        check_eq("t1_busy_len", 64'(busy_cnt - b0), 64'd240);
        check_eq("t1_ovr", {63'd0, overrun}, 64'd0);

        // 2: second sample held, sent back-to-back
        base = rx_q.size(); b0 = busy_cnt; f0 = busy_falls;
        strobe(16'h0009);
        repeat (50) @(negedge clk);
        strobe(16'hFFFF);
        wait_idle(800);
        check_line("t2_line0", base, 48'h30_30_30_39_0D_0A);
        check_line("t2_line1", base + 6, 48'h46_46_46_46_0D_0A);
        check_eq("t2_nbytes", 64'(rx_q.size() - base), 64'd12);
        check_eq("t2_busy_len", 64'(busy_cnt - b0), 64'd480);
        check_eq("t2_busy_falls", 64'(busy_falls - f0), 64'd1);
        check_eq("t2_ovr", {63'd0, overrun}, 64'd0);

        // 3: holding overwritten, newest wins, overrun sticky
        base = rx_q.size();
        strobe(16'h1234);
        repeat (20) @(negedge clk);
        strobe(16'h5555);
        repeat (20) @(negedge clk);
        strobe(16'hABCD);
        wait_idle(800);
        check_line("t3_line0", base, 48'h31_32_33_34_0D_0A);
        check_line("t3_line1", base + 6, 48'h41_42_43_44_0D_0A);
        check_eq("t3_nbytes", 64'(rx_q.size() - base), 64'd12);
        check_eq("t3_ovr", {63'd0, overrun}, 64'd1);
        repeat (100) @(negedge clk);
        check_eq("t3_ovr_sticky", {63'd0, overrun}, 64'd1);

        // 4: enable dropped mid-line
        do_reset();
        check_eq("t4_ovr_rst", {63'd0, overrun}, 64'd0);
        base = rx_q.size();
        strobe(16'h0000);
        repeat (99) @(negedge clk);
        enable = 1'b0;
        repeat (19) @(negedge clk);
        strobe(16'h1111);
        wait_idle(400);
        repeat (300) @(negedge clk);
        check_line("t4_line", base, 48'h30_30_30_30_0D_0A);
        check_eq("t4_nbytes", 64'(rx_q.size() - base), 64'd6);
        check_eq("t4_busy", {63'd0, busy}, 64'd0);
        check_eq("t4_ovr", {63'd0, overrun}, 64'd0);
        enable = 1'b1;

        // 5: reset mid-line, then clean line
        strobe(16'hBEEF);
        repeat (69) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t5_rst_txd", {63'd0, txd}, 64'd1);
        check_eq("t5_rst_busy", {63'd0, busy}, 64'd0);
        repeat (60) @(negedge clk);
        base = rx_q.size();
        strobe(16'h0001);
        wait_idle(400);
        check_line("t5_line", base, 48'h30_30_30_31_0D_0A);
        check_eq("t5_nbytes", 64'(rx_q.size() - base), 64'd6);

        // 6: strobe on the exact line-end cycle while holding is full
        base = rx_q.size(); b0 = busy_cnt; f0 = busy_falls;
        strobe(16'hC0DE);
        repeat (10) @(negedge clk);
        strobe(16'h0F1E);
        repeat (226) @(negedge clk);
        strobe(16'h7A5B);
        wait_idle(1000);
        check_line("t6_line0", base, 48'h43_30_44_45_0D_0A);
        check_line("t6_line1", base + 6, 48'h30_46_31_45_0D_0A);
        check_line("t6_line2", base + 12, 48'h37_41_35_42_0D_0A);
        check_eq("t6_nbytes", 64'(rx_q.size() - base), 64'd18);
        check_eq("t6_busy_len", 64'(busy_cnt - b0), 64'd720);
        check_eq("t6_busy_falls", 64'(busy_falls - f0), 64'd1);
        check_eq("t6_ovr", {63'd0, overrun}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
